// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit limit and
// buffers returned words with their PCs in an in-order queue that feeds decode.
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = CW + 2;
   localparam logic [AW-1:0] PTR_ZERO   = AW'(1'b0);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
   localparam logic [SW-1:0] CREDIT_MAX = SW'(DEPTH);
   localparam logic [31:0]   WORD_MASK  = 32'hFFFF_FFFC;

   logic [31:0]   pc_r;
   logic [31:0]   q_inst_r [DEPTH];
   logic [31:0]   q_pc_r   [DEPTH];
   logic [31:0]   tag_pc_r [DEPTH];
   logic [AW-1:0] q_rd_r;
   logic [AW-1:0] q_wr_r;
   logic [AW-1:0] tag_rd_r;
   logic [AW-1:0] tag_wr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] outst_r;
   logic [CW-1:0] drop_r;
   logic          id_valid_r;
   logic [31:0]   id_inst_r;
   logic [31:0]   id_pc_r;

   logic [SW-1:0] credit_sum_s;
   logic          issue_s;
   logic          resp_s;
   logic          drop_resp_s;
   logic          push_s;
   logic          pop_s;
   logic [CW-1:0] issue_inc_s;
   logic [CW-1:0] resp_dec_s;
   logic [CW-1:0] push_inc_s;
   logic [CW-1:0] pop_dec_s;
   logic [CW-1:0] count_nxt_s;
   logic [CW-1:0] outst_nxt_s;
   logic [CW-1:0] drop_nxt_s;
   logic [CW-1:0] remain_s;
   logic [AW-1:0] q_rd_nxt_s;
   logic [31:0]   resp_pc_s;
   logic [31:0]   head_inst_s;
   logic [31:0]   head_pc_s;

   assign imem_addr = pc_r;
   assign id_valid  = id_valid_r;
   assign id_inst   = id_inst_r;
   assign id_pc     = id_pc_r;
   assign resp_pc_s = tag_pc_r[tag_rd_r];

   // Request credit: queued words plus every live or doomed request must fit the queue.
   always_comb begin
      credit_sum_s = SW'(count_r) + SW'(outst_r) + SW'(drop_r);
      if (reset_n && (credit_sum_s < CREDIT_MAX)) begin
         imem_req = 1'b1;
      end else begin
         imem_req = 1'b0;
      end
   end

   // Per-cycle events; a redirect voids this cycle's push and pop.
   always_comb begin
      issue_s     = imem_req & imem_gnt;
      resp_s      = imem_rvalid & ((outst_r != CNT_ZERO) | (drop_r != CNT_ZERO));
      drop_resp_s = resp_s & (drop_r != CNT_ZERO);
      push_s      = resp_s & ~drop_resp_s & ~redirect_valid;
      pop_s       = id_valid_r & id_ready & ~redirect_valid;
      issue_inc_s = issue_s ? CNT_ONE : CNT_ZERO;
      resp_dec_s  = resp_s ? CNT_ONE : CNT_ZERO;
      push_inc_s  = push_s ? CNT_ONE : CNT_ZERO;
      pop_dec_s   = pop_s ? CNT_ONE : CNT_ZERO;
   end

   // Next values for occupancy, live-request and discard counters.
   always_comb begin
      count_nxt_s = count_r;
      outst_nxt_s = outst_r;
      drop_nxt_s  = drop_r;
      if (redirect_valid) begin
         count_nxt_s = CNT_ZERO;
         outst_nxt_s = CNT_ZERO;
         // every request still in flight, including one granted now, becomes a discard
         drop_nxt_s  = drop_r + outst_r + issue_inc_s - resp_dec_s;
      end else if (drop_resp_s) begin
         count_nxt_s = count_r - pop_dec_s;
         outst_nxt_s = outst_r + issue_inc_s;
         drop_nxt_s  = drop_r - CNT_ONE;
      end else begin
         count_nxt_s = count_r + push_inc_s - pop_dec_s;
         outst_nxt_s = outst_r + issue_inc_s - resp_dec_s;
         drop_nxt_s  = drop_r;
      end
   end

   // Next head of queue for the registered decode outputs.
   always_comb begin
      remain_s    = count_r - pop_dec_s;
      q_rd_nxt_s  = pop_s ? (q_rd_r + PTR_ONE) : q_rd_r;
      head_inst_s = id_inst_r;
      head_pc_s   = id_pc_r;
      if (redirect_valid) begin
         head_inst_s = id_inst_r;
         head_pc_s   = id_pc_r;
      end else if (remain_s != CNT_ZERO) begin
         head_inst_s = q_inst_r[q_rd_nxt_s];
         head_pc_s   = q_pc_r[q_rd_nxt_s];
      end else if (push_s) begin
         // queue drains to empty this cycle, so the arriving word becomes the head
         head_inst_s = imem_rdata;
         head_pc_s   = resp_pc_s;
      end else begin
         head_inst_s = id_inst_r;
         head_pc_s   = id_pc_r;
      end
   end

   // PC, counters and decode-facing output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_r       <= RESET_PC & WORD_MASK;
         count_r    <= CNT_ZERO;
         outst_r    <= CNT_ZERO;
         drop_r     <= CNT_ZERO;
         id_valid_r <= 1'b0;
         id_inst_r  <= 32'h0000_0000;
         id_pc_r    <= 32'h0000_0000;
      end else begin
         if (redirect_valid) begin
            pc_r <= redirect_pc & WORD_MASK;
         end else if (issue_s) begin
            pc_r <= pc_r + 32'd4;
         end else begin
            pc_r <= pc_r;
         end
         count_r    <= count_nxt_s;
         outst_r    <= outst_nxt_s;
         drop_r     <= drop_nxt_s;
         id_valid_r <= (count_nxt_s != CNT_ZERO);
         id_inst_r  <= head_inst_s;
         id_pc_r    <= head_pc_s;
      end
   end

   // Instruction queue storage and pointers; cleared on redirect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_rd_r <= PTR_ZERO;
         q_wr_r <= PTR_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            q_inst_r[i] <= 32'h0000_0000;
            q_pc_r[i]   <= 32'h0000_0000;
         end
      end else if (redirect_valid) begin
         q_rd_r <= PTR_ZERO;
         q_wr_r <= PTR_ZERO;
      end else begin
         q_rd_r <= q_rd_nxt_s;
         if (push_s) begin
            q_inst_r[q_wr_r] <= imem_rdata;
            q_pc_r[q_wr_r]   <= resp_pc_s;
            q_wr_r           <= q_wr_r + PTR_ONE;
         end else begin
            q_wr_r <= q_wr_r;
         end
      end
   end

   // PC tags of issued requests, consumed in order by every accepted response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_rd_r <= PTR_ZERO;
         tag_wr_r <= PTR_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            tag_pc_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (issue_s) begin
            tag_pc_r[tag_wr_r] <= pc_r;
            tag_wr_r           <= tag_wr_r + PTR_ONE;
         end else begin
            tag_wr_r <= tag_wr_r;
         end
         if (resp_s) begin
            tag_rd_r <= tag_rd_r + PTR_ONE;
         end else begin
            tag_rd_r <= tag_rd_r;
         end
      end
   end

endmodule
